cpu_bus_bridge_2x: RTL and testbench
====================================

Name: cpu_bus_bridge_2x

Overview:
- Single-clock CPU↔peripheral bus bridge running entirely in the 2x domain.
- The 1x CPU is phase-aligned to clk_2x, so its signals are sampled directly, qualified by a phase strobe.
- Adds parametrised widths, a peripheral handshake with timeout and error response, phase-aligned ready pulses, and per-line edge-latched IRQs with EOI clear.
- Sits between the CPU core and the 2x peripheral interconnect.

Parameters:
ADDR_W, 24, CPU/peripheral address width
DATA_W, 32, data width; must be a multiple of 8
IRQ_COUNT, 32, number of interrupt lines
TIMEOUT, 64, 2x cycles before an unanswered peripheral request errors; 0 disables the timeout
ERROR_DATA, 32'hFFFF_FFFF, read data returned on timeout, truncated or zero-extended to DATA_W

Ports:
clk_2x  in  1  2x clock
reset  in  1  asynchronous, active-high reset
clk_1x_phase  in  1  high in the 2x cycle whose closing edge coincides with a clk_1x posedge
cpu_mem_valid  in  1  CPU request valid (1x-timed)
cpu_address  in  ADDR_W  request address
cpu_wstrb  in  DATA_W/8  byte write strobes; 0 means read
cpu_write_data  in  DATA_W  write data
cpu_mem_ready  out  1  response valid, spans one full 1x period
cpu_read_data  out  DATA_W  response data
cpu_bus_error  out  1  response is a timeout error
periph_valid  out  1  peripheral request
periph_address  out  ADDR_W  registered address
periph_wstrb  out  DATA_W/8  registered strobes
periph_write_data  out  DATA_W  registered write data
periph_ready  in  1  peripheral completion, one-cycle pulse
periph_read_data  in  DATA_W  valid while periph_ready is high
irq_in  in  IRQ_COUNT  level interrupt sources (2x domain)
cpu_eoi  in  IRQ_COUNT  end-of-interrupt bits (1x-timed)
cpu_irq  out  IRQ_COUNT  latched pending interrupts to CPU

Behaviour:
- Reset: state IDLE. All outputs 0: periph_valid, periph_*, cpu_mem_ready, cpu_bus_error, cpu_read_data, cpu_irq. Timeout counter 0. Edge-detect history 0.
- All outputs are registered.
- State machine: IDLE → ISSUE → ALIGN → RESP → IDLE.
- IDLE:
  - On a cycle with clk_1x_phase && cpu_mem_valid, register address, wstrb and write data, clear the counter, and go to ISSUE.
  - cpu_mem_valid is ignored when clk_1x_phase is low.
- ISSUE:
  - periph_valid is high; periph_* are stable.
  - periph_ready: capture periph_read_data, set error=0, go to ALIGN.
  - Otherwise, if TIMEOUT≠0 and counter==TIMEOUT-1: data=ERROR_DATA, error=1, go to ALIGN.
  - Otherwise, increment the counter.
  - If ready and timeout occur in the same cycle, ready wins.
  - periph_valid deasserts on leaving ISSUE.
- ALIGN: wait until a clk_1x_phase cycle, then go to RESP.
- RESP:
  - Lasts exactly 2 cycles: the non-phase cycle, then the phase cycle.
  - cpu_mem_ready=1; cpu_read_data and cpu_bus_error are held.
  - After the phase cycle, return to IDLE with ready, error and data cleared to 0.
  - The CPU drops valid at that same 1x edge, so there is no re-acceptance.
- Minimum latency (zero-wait peripheral): valid sampled at 1x edge N, ready sampled by the CPU at 1x edge N+2.
- Writes return cpu_read_data = captured periph_read_data (don't-care to the CPU).
- IRQ path:
  - irq_prev is registered each cycle.
  - cpu_irq[i] is set when irq_in[i] && !irq_prev[i].
  - cpu_irq[i] is cleared when clk_1x_phase && cpu_eoi[i].
  - If set and clear occur in the same cycle, set wins.
  - A level held high does not re-set the bit after EOI.
- Reset mid-transaction: periph_valid drops immediately. The peripheral must tolerate an abandoned request.

Decomposition:
- Shared package cpu_bus_bridge_pkg holds the state encoding constants (IDLE, ISSUE, ALIGN, RESP).
- One sub-module, cpu_irq_latch (param IRQ_COUNT), contains the edge detect, set/clear logic and set-priority.
- The FSM and datapath stay in the top module.

Test Plan:
- Read, periph_ready 1 cycle after periph_valid, data 32'h1234_5678 → cpu_mem_ready high for exactly 2 clk_2x cycles ending on a phase cycle; read data 32'h1234_5678; error 0; ready seen at 1x edge N+2.
- Write addr 24'h00_4010, wstrb 4'b0011, data 32'hCAFE_BABE, ready after 5 cycles → periph_* match throughout ISSUE; one ready pulse; error 0.
- No periph_ready, TIMEOUT=64 → periph_valid high exactly 64 cycles; ready with error=1 and data 32'hFFFF_FFFF. Ready and timeout together on cycle 64 → error=0.
- Valid asserted in a non-phase cycle only → no request issued. Back-to-back requests → second accepted only after RESP, with no duplicate periph_valid.
- irq_in[3] rises and stays high → cpu_irq[3]=1. EOI on a phase cycle → 0 and stays 0. irq_in[3] edge coinciding with EOI → stays 1.
- reset asserted during ISSUE → periph_valid, cpu_mem_ready and cpu_irq go to 0 asynchronously. Next request after release completes normally.

Source files
------------

// File: rtl/cpu_bus_bridge_pkg.sv
// Shared definitions for the 2x-domain CPU/peripheral bridge.
// IDLE: wait for phased request | ISSUE: periph_valid up | ALIGN: wait for phase | RESP: cpu_mem_ready up
package cpu_bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ALIGN = 2'd2,
    RESP  = 2'd3
  } bridge_state_e;

  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/cpu_bus_bridge_2x_if.sv
// CPU, peripheral and interrupt signals of the bridge; slave = bridge side, master = surroundings.
interface cpu_bus_bridge_2x_if #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int IRQ_COUNT = 32
);
  logic                  clk_1x_phase;
  logic                  cpu_mem_valid;
  logic [ADDR_W-1:0]     cpu_address;
  logic [DATA_W/8-1:0]   cpu_wstrb;
  logic [DATA_W-1:0]     cpu_write_data;
  logic                  cpu_mem_ready;
  logic [DATA_W-1:0]     cpu_read_data;
  logic                  cpu_bus_error;
  logic                  periph_valid;
  logic [ADDR_W-1:0]     periph_address;
  logic [DATA_W/8-1:0]   periph_wstrb;
  logic [DATA_W-1:0]     periph_write_data;
  logic                  periph_ready;
  logic [DATA_W-1:0]     periph_read_data;
  logic [IRQ_COUNT-1:0]  irq_in;
  logic [IRQ_COUNT-1:0]  cpu_eoi;
  logic [IRQ_COUNT-1:0]  cpu_irq;

  modport slave (
    input  clk_1x_phase, cpu_mem_valid, cpu_address, cpu_wstrb, cpu_write_data,
    input  periph_ready, periph_read_data, irq_in, cpu_eoi,
    output cpu_mem_ready, cpu_read_data, cpu_bus_error,
    output periph_valid, periph_address, periph_wstrb, periph_write_data, cpu_irq
  );

  modport master (
    output clk_1x_phase, cpu_mem_valid, cpu_address, cpu_wstrb, cpu_write_data,
    output periph_ready, periph_read_data, irq_in, cpu_eoi,
    input  cpu_mem_ready, cpu_read_data, cpu_bus_error,
    input  periph_valid, periph_address, periph_wstrb, periph_write_data, cpu_irq
  );
endinterface

// File: rtl/cpu_irq_latch.sv
// Rising-edge interrupt latch; EOI clears on phase cycles, a new edge beats a same-cycle EOI.
module cpu_irq_latch #(
  parameter int IRQ_COUNT = 32
) (
  input  logic                 clk_2x,
  input  logic                 reset,
  input  logic                 phase_i,
  input  logic [IRQ_COUNT-1:0] irq_i,
  input  logic [IRQ_COUNT-1:0] eoi_i,
  output logic [IRQ_COUNT-1:0] irq_o
);
  logic [IRQ_COUNT-1:0] prev_q;
  logic [IRQ_COUNT-1:0] pend_q, pend_d;
  logic [IRQ_COUNT-1:0] set_w, clr_w;

  assign set_w = irq_i & ~prev_q;
  assign clr_w = phase_i ? eoi_i : '0;

  always_comb begin
    pend_d = (pend_q & ~clr_w) | set_w;
  end

  always_ff @(posedge clk_2x or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= irq_i;
      pend_q <= pend_d;
    end
  end

  assign irq_o = pend_q;
endmodule

// File: rtl/cpu_bus_bridge_2x.sv
// CPU-to-peripheral bridge in the 2x domain: phased request capture, peripheral handshake
// with timeout/error response, 1x-aligned two-cycle ready pulse, and the IRQ latch.
module cpu_bus_bridge_2x
  import cpu_bus_bridge_pkg::*;
#(
  parameter int          ADDR_W     = 24,
  parameter int          DATA_W     = 32,
  parameter int          IRQ_COUNT  = 32,
  parameter int          TIMEOUT    = 64,
  parameter logic [31:0] ERROR_DATA = 32'hFFFF_FFFF
) (
  input logic                clk_2x,
  input logic                reset,
  cpu_bus_bridge_2x_if.slave bus
);
  localparam int                 STRB_W   = DATA_W / 8;
  localparam int                 CNT_W    = cnt_width(TIMEOUT);
  localparam bit                 TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [DATA_W-1:0]  ERR_DATA = DATA_W'(ERROR_DATA);

  bridge_state_e       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pvalid_q, pvalid_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pvalid_d = pvalid_q;
    paddr_d  = paddr_q;
    pstrb_d  = pstrb_q;
    pwdata_d = pwdata_q;
    ready_d  = ready_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.clk_1x_phase && bus.cpu_mem_valid) begin
          paddr_d  = bus.cpu_address;
          pstrb_d  = bus.cpu_wstrb;
          pwdata_d = bus.cpu_write_data;
          cnt_d    = '0;
          pvalid_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // Completion is checked first so a same-cycle ready beats the timeout.
        if (bus.periph_ready) begin
          rdata_d  = bus.periph_read_data;
          err_d    = 1'b0;
          pvalid_d = 1'b0;
          state_d  = ALIGN;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rdata_d  = ERR_DATA;
          err_d    = 1'b1;
          pvalid_d = 1'b0;
          state_d  = ALIGN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ALIGN: begin
        if (bus.clk_1x_phase) begin
          ready_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // RESP is always entered on a non-phase cycle, so the phase cycle is its second one.
        if (bus.clk_1x_phase) begin
          ready_d = 1'b0;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_2x or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pvalid_q <= 1'b0;
      paddr_q  <= '0;
      pstrb_q  <= '0;
      pwdata_q <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pvalid_q <= pvalid_d;
      paddr_q  <= paddr_d;
      pstrb_q  <= pstrb_d;
      pwdata_q <= pwdata_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.periph_valid      = pvalid_q;
  assign bus.periph_address    = paddr_q;
  assign bus.periph_wstrb      = pstrb_q;
  assign bus.periph_write_data = pwdata_q;
  assign bus.cpu_mem_ready     = ready_q;
  assign bus.cpu_bus_error     = err_q;
  assign bus.cpu_read_data     = rdata_q;

  cpu_irq_latch #(.IRQ_COUNT(IRQ_COUNT)) u_irq_latch (
    .clk_2x  (clk_2x),
    .reset   (reset),
    .phase_i (bus.clk_1x_phase),
    .irq_i   (bus.irq_in),
    .eoi_i   (bus.cpu_eoi),
    .irq_o   (bus.cpu_irq)
  );
endmodule

// File: tb/tb_cpu_bus_bridge_2x.sv
// Bench for cpu_bus_bridge_2x: directed and randomized transactions and IRQ traffic
// checked against a transaction-level latency/result model and a per-line IRQ model.
module tb_cpu_bus_bridge_2x;
  localparam int TO = 64;

  logic clk_2x = 1'b0;
  logic reset;

  cpu_bus_bridge_2x_if #(.ADDR_W(24), .DATA_W(32), .IRQ_COUNT(32)) bus ();

  cpu_bus_bridge_2x #(
    .ADDR_W(24), .DATA_W(32), .IRQ_COUNT(32), .TIMEOUT(TO), .ERROR_DATA(32'hFFFF_FFFF)
  ) dut (
    .clk_2x (clk_2x),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_2x = ~clk_2x;

  int total = 0;
  int bad   = 0;
  logic [31:0] pend_m = '0;
  logic [31:0] prev_m = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 2x cycle: advance the IRQ model, cross the edge, flip phase for the next cycle.
  task automatic tick();
    logic [31:0] nxt, nprev;
    nxt   = (pend_m & ~(bus.clk_1x_phase ? bus.cpu_eoi : 32'h0)) | (bus.irq_in & ~prev_m);
    nprev = bus.irq_in;
    @(posedge clk_2x);
    if (!reset) begin
      pend_m = nxt;
      prev_m = nprev;
    end
    #1;
    bus.clk_1x_phase = ~bus.clk_1x_phase;
  endtask

  // k = cycle of periph_valid in which the peripheral answers; k > TO means never.
  task automatic txn(input string tag, input logic [23:0] a, input logic [3:0] s,
                     input logic [31:0] wd, input int k, input logic [31:0] rd);
    int vcnt = 0, rises = 0, rcnt = 0, cyc = 0, first_r = -1, ke;
    logic pv_prev = 1'b0, mism = 1'b0, got_e = 1'b0, done = 1'b0;
    logic [31:0] got_d = '0;
    ke = (k > TO) ? TO : k;
    if (!bus.clk_1x_phase) tick();
    bus.cpu_mem_valid  = 1'b1;
    bus.cpu_address    = a;
    bus.cpu_wstrb      = s;
    bus.cpu_write_data = wd;
    tick();
    for (int i = 0; i < 400 && !done; i++) begin
      cyc++;
      if (bus.periph_valid) begin
        vcnt++;
        if (!pv_prev) rises++;
        if (bus.periph_address !== a || bus.periph_wstrb !== s || bus.periph_write_data !== wd)
          mism = 1'b1;
      end
      pv_prev = bus.periph_valid;
      bus.periph_ready     = bus.periph_valid && (vcnt == k);
      bus.periph_read_data = bus.periph_ready ? rd : $urandom();
      if (bus.cpu_mem_ready) begin
        rcnt++;
        if (first_r < 0) first_r = cyc;
        got_d = bus.cpu_read_data;
        got_e = bus.cpu_bus_error;
        if (bus.clk_1x_phase) done = 1'b1;
      end
      tick();
    end
    bus.periph_ready  = 1'b0;
    bus.cpu_mem_valid = 1'b0;
    chk({tag, ".done"},    64'(done), 64'd1);
    chk({tag, ".vcycles"}, 64'(vcnt), 64'(ke));
    chk({tag, ".vrises"},  64'(rises), 64'd1);
    chk({tag, ".pstable"}, 64'(mism), 64'd0);
    chk({tag, ".rcycles"}, 64'(rcnt), 64'd2);
    chk({tag, ".rfirst"},  64'(first_r), 64'(cyc - 1));
    chk({tag, ".latency"}, 64'(cyc), 64'(2 * (ke / 2 + 2)));
    chk({tag, ".rdata"},   64'(got_d), 64'((k > TO) ? 32'hFFFF_FFFF : rd));
    chk({tag, ".err"},     64'(got_e), 64'(k > TO));
  endtask

  initial begin
    logic seen;
    reset                = 1'b1;
    bus.clk_1x_phase     = 1'b0;
    bus.cpu_mem_valid    = 1'b0;
    bus.cpu_address      = '0;
    bus.cpu_wstrb        = '0;
    bus.cpu_write_data   = '0;
    bus.periph_ready     = 1'b0;
    bus.periph_read_data = '0;
    bus.irq_in           = '0;
    bus.cpu_eoi          = '0;
    repeat (3) tick();
    chk("rst.pvalid", 64'(bus.periph_valid), 64'd0);
    chk("rst.pbus",   {bus.periph_address, bus.periph_wstrb, bus.periph_write_data}, 64'd0);
    chk("rst.ready",  64'(bus.cpu_mem_ready), 64'd0);
    chk("rst.rdata",  {31'd0, bus.cpu_bus_error, bus.cpu_read_data}, 64'd0);
    chk("rst.irq",    64'(bus.cpu_irq), 64'd0);
    reset = 1'b0;
    tick();

    txn("rd_k1",   24'h00_0100, 4'b0000, 32'h0,           1,    32'h1234_5678);
    txn("wr_k5",   24'h00_4010, 4'b0011, 32'hCAFE_BABE,   5,    32'h0BAD_F00D);
    txn("tmo",     24'h12_3456, 4'b0000, 32'h0,           1000, 32'h5555_AAAA);
    txn("tmo_tie", 24'h65_4321, 4'b1111, 32'h8765_4321,   TO,   32'hA5A5_0001);
    for (int n = 0; n < 6; n++)
      txn("rand", 24'($urandom()), 4'($urandom()), $urandom(), $urandom_range(1, 9), $urandom());

    // Valid offered only in a non-phase cycle must be ignored.
    if (bus.clk_1x_phase) tick();
    bus.cpu_mem_valid = 1'b1;
    bus.cpu_address   = 24'hDE_AD00;
    tick();
    bus.cpu_mem_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.periph_valid) seen = 1'b1;
      tick();
    end
    chk("nophase.pvalid", 64'(seen), 64'd0);

    // IRQ line 3: edge set, held level, EOI, edge-vs-EOI priority, non-phase EOI ignored.
    bus.irq_in[3] = 1'b1;
    tick(); tick();
    chk("irq.set", 64'(bus.cpu_irq), 64'h8);
    repeat (3) tick();
    chk("irq.hold", 64'(bus.cpu_irq), 64'h8);
    if (!bus.clk_1x_phase) tick();
    bus.cpu_eoi[3] = 1'b1;
    tick();
    bus.cpu_eoi[3] = 1'b0;
    chk("irq.eoi", 64'(bus.cpu_irq), 64'h0);
    repeat (4) tick();
    chk("irq.level_no_reset", 64'(bus.cpu_irq), 64'h0);
    bus.irq_in[3] = 1'b0;
    tick();
    bus.irq_in[3] = 1'b1;
    tick();
    bus.irq_in[3] = 1'b0;
    tick();
    if (!bus.clk_1x_phase) tick();
    bus.irq_in[3]  = 1'b1;
    bus.cpu_eoi[3] = 1'b1;
    tick();
    bus.cpu_eoi[3] = 1'b0;
    chk("irq.set_wins", 64'(bus.cpu_irq), 64'h8);
    if (bus.clk_1x_phase) tick();
    bus.cpu_eoi = '1;
    tick();
    bus.cpu_eoi = '0;
    chk("irq.eoi_nophase", 64'(bus.cpu_irq), 64'h8);
    for (int i = 0; i < 60; i++) begin
      bus.irq_in  = $urandom();
      bus.cpu_eoi = $urandom();
      tick();
      chk("irq.rand", 64'(bus.cpu_irq), 64'(pend_m));
    end
    bus.irq_in  = 32'hF0F0_F0F0;
    bus.cpu_eoi = '0;
    tick();
    bus.irq_in = '0;
    tick();

    // Asynchronous reset in the middle of ISSUE.
    if (!bus.clk_1x_phase) tick();
    bus.cpu_mem_valid = 1'b1;
    bus.cpu_address   = 24'h00_0ABC;
    tick();
    repeat (3) tick();
    chk("mid.pvalid_pre", 64'(bus.periph_valid), 64'd1);
    chk("mid.irq_pre",    64'(bus.cpu_irq), 64'(pend_m));
    #2;
    reset = 1'b1;
    #1;
    chk("mid.pvalid", 64'(bus.periph_valid), 64'd0);
    chk("mid.ready",  64'(bus.cpu_mem_ready), 64'd0);
    chk("mid.irq",    64'(bus.cpu_irq), 64'd0);
    bus.cpu_mem_valid = 1'b0;
    pend_m = '0;
    prev_m = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    txn("post_rst", 24'h00_0200, 4'b0000, 32'h0, 2, 32'h3C3C_C3C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
